// File: rtl/led_matrix_scanner.sv
// HUB75 1/16-scan driver for a 64x32 panel using binary-code modulation over bit-planes.
// Latency: colour bits appear in the third cycle of each column, one cycle after the lower-pixel read.
// No backpressure: free-running scan; swap requests are held until the next frame boundary.
module led_matrix_scanner #(
    parameter int COLS      = 64,
    parameter int BASE_TIME = 32,
    parameter int PLANES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swap_req,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [23:0] mem_rdata,
    output logic        mem_change,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        r2,
    output logic        g2,
    output logic        b2,
    output logic [3:0]  row_addr,
    output logic        pclk,
    output logic        lat,
    output logic        oe_n,
    output logic        frame_start
);

    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int DW  = $clog2(BASE_TIME << (PLANES - 1)) + 1;
    localparam int LSB = 8 - PLANES;

    typedef enum logic [1:0] {
        SHIFT     = 2'd0,
        LATCH     = 2'd1,
        DISPLAY   = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col;
    logic [1:0]      k;
    logic [3:0]      row;
    logic [PW-1:0]   plane;
    logic [DW-1:0]   disp_cnt;
    logic [DW-1:0]   disp_len;
    logic            swap_pend;
    logic [3:0]      row_q;
    logic [23:0]     upper_q;
    logic [5:0]      rgb_hold;
    logic [5:0]      rgb_live;
    logic [2:0]      bit_sel;
    logic [4:0]      mem_row;
    logic            last_col;
    logic            last_plane;
    logic            disp_done;

    // Shared decode of counter end conditions and the current plane's bit position
    always_comb begin
        last_col   = (col == CW'(COLS - 1));
        last_plane = (plane == PW'(PLANES - 1));
        disp_done  = (disp_cnt == '0);
        disp_len   = DW'(BASE_TIME) << plane;
        bit_sel    = 3'(LSB) + 3'(plane);
        mem_row    = (k == 2'd1) ? {1'b1, row} : {1'b0, row};
        rgb_live   = {upper_q[16 + int'(bit_sel)], upper_q[8 + int'(bit_sel)], upper_q[int'(bit_sel)],
                      mem_rdata[16 + int'(bit_sel)], mem_rdata[8 + int'(bit_sel)], mem_rdata[int'(bit_sel)]};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHIFT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and HUB75/memory strobes; reset forces idle outputs in the same cycle
    always_comb begin
        state_nxt                  = state;
        mem_rd                     = 1'b0;
        mem_addr                   = '0;
        mem_change                 = 1'b0;
        pclk                       = 1'b0;
        lat                        = 1'b0;
        oe_n                       = 1'b1;
        frame_start                = 1'b0;
        {r1, g1, b1, r2, g2, b2}   = rgb_hold;
        row_addr                   = row_q;
        case (state)
            SHIFT: begin
                if (k == 2'd3 && last_col) begin
                    state_nxt = LATCH;
                end
                if (k < 2'd2) begin
                    mem_rd   = 1'b1;
                    mem_addr = 12'(int'(mem_row) * COLS + int'(col));
                end
                if (k == 2'd2) begin
                    {r1, g1, b1, r2, g2, b2} = rgb_live;
                end
                if (k == 2'd3) begin
                    pclk = 1'b1;
                end
            end
            LATCH: begin
                state_nxt = DISPLAY;
                lat       = 1'b1;
            end
            DISPLAY: begin
                oe_n = 1'b0;
                if (disp_done) begin
                    state_nxt = (last_plane && row == 4'd15) ? FRAME_END : SHIFT;
                end
            end
            FRAME_END: begin
                state_nxt   = SHIFT;
                frame_start = 1'b1;
                mem_change  = swap_pend | swap_req;
            end
            default: state_nxt = SHIFT;
        endcase
        if (rst) begin
            mem_rd                   = 1'b0;
            mem_addr                 = '0;
            mem_change               = 1'b0;
            pclk                     = 1'b0;
            lat                      = 1'b0;
            oe_n                     = 1'b1;
            frame_start              = 1'b0;
            {r1, g1, b1, r2, g2, b2} = 6'b0;
            row_addr                 = 4'd0;
        end
    end

    // Scan counters, pixel capture and colour/row holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            k        <= 2'd0;
            row      <= 4'd0;
            plane    <= '0;
            disp_cnt <= '0;
            upper_q  <= '0;
            rgb_hold <= '0;
            row_q    <= 4'd0;
        end else begin
            case (state)
                SHIFT: begin
                    k <= k + 2'd1;
                    if (k == 2'd1) begin
                        upper_q <= mem_rdata;
                    end
                    if (k == 2'd2) begin
                        rgb_hold <= rgb_live;
                    end
                    if (k == 2'd3) begin
                        col <= last_col ? '0 : col + CW'(1);
                    end
                end
                LATCH: begin
                    row_q    <= row;
                    disp_cnt <= disp_len - DW'(1);
                end
                DISPLAY: begin
                    if (!disp_done) begin
                        disp_cnt <= disp_cnt - DW'(1);
                    end else begin
                        plane <= last_plane ? '0 : plane + PW'(1);
                        if (last_plane) begin
                            row <= row + 4'd1;
                        end
                    end
                end
                FRAME_END: begin
                    col   <= '0;
                    k     <= 2'd0;
                    row   <= 4'd0;
                    plane <= '0;
                end
                default: begin
                    k <= 2'd0;
                end
            endcase
        end
    end

    // Swap request latch: any request before or during the boundary cycle is served there once
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_pend <= 1'b0;
        end else if (state == FRAME_END) begin
            swap_pend <= 1'b0;
        end else if (swap_req) begin
            swap_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: random pixel memory and swap timing, compared cycle by cycle
// against a frame-timeline model derived from the scan rules (position decoded from cycle count).
// Double-buffered memory model with one-cycle read latency.
module tb_led_matrix_scanner;

    localparam int COLS   = 64;
    localparam int BASE   = 2;
    localparam int PL     = 4;
    localparam int LSB    = 8 - PL;
    localparam int ROWLEN = PL * (4 * COLS + 1) + BASE * ((1 << PL) - 1);
    localparam int FLEN   = 16 * ROWLEN + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swap_req = 1'b0;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [23:0] mem_rdata;
    logic        mem_change;
    logic        r1, g1, b1, r2, g2, b2;
    logic [3:0]  row_addr;
    logic        pclk, lat, oe_n, frame_start;

    int tests = 0;
    int fails = 0;
    int cur_cyc = 0;

    logic [23:0] mem [2][4096];
    int          bank = 0;

    always #5 clk = ~clk;

    led_matrix_scanner #(.COLS(COLS), .BASE_TIME(BASE), .PLANES(PL)) dut (
        .clk(clk), .rst(rst), .swap_req(swap_req),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_change(mem_change),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .row_addr(row_addr), .pclk(pclk), .lat(lat), .oe_n(oe_n), .frame_start(frame_start)
    );

    // Pixel memory: registered read, bank flips on the exchange pulse
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[bank][mem_addr];
        if (mem_change) bank <= 1 - bank;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", tag, cur_cyc, got, exp);
        end
    endtask

    // Locate cycle tt of a frame: kind 0=shift 1=latch 2=display 3=frame end
    function automatic void decode(input int tt, output int kind, output int row,
                                   output int pl, output int col, output int k);
        int u;
        kind = 0; row = 0; pl = 0; col = 0; k = 0;
        if (tt == FLEN - 1) begin
            kind = 3;
        end else begin
            row = tt / ROWLEN;
            u   = tt % ROWLEN;
            for (int p = 0; p < PL; p++) begin
                int seg;
                seg = 4 * COLS + 1 + (BASE << p);
                if (u < seg) begin
                    pl = p;
                    break;
                end
                u -= seg;
            end
            if (u < 4 * COLS) begin
                kind = 0; col = u / 4; k = u % 4;
            end else if (u == 4 * COLS) begin
                kind = 1;
            end else begin
                kind = 2;
            end
        end
    endfunction

    function automatic logic [5:0] pix_bits(input int mb, input int row, input int col, input int pl);
        logic [23:0] up, lo;
        int b;
        up = mem[mb][row * COLS + col];
        lo = mem[mb][(row + 16) * COLS + col];
        b  = LSB + pl;
        return {up[16 + b], up[8 + b], up[b], lo[16 + b], lo[8 + b], lo[b]};
    endfunction

    initial begin
        int t, kind, row, pl, col, k;
        int frame_idx, mbank, rst_cnt, fs2, fs3;
        int mc_cnt [5];
        int s [3];
        bit pend, rst_done, exp_mc;
        logic [3:0] row_lat;
        logic [5:0] hold, exp_col;
        logic [27:0] got_v, exp_v;

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 4096; a++)
                mem[b][a] = 24'($urandom);
        mem[0][5]              = 24'hF0F0F0;
        mem[0][16 * COLS + 5]  = 24'hF0F0F0;
        mem[0][3 * COLS + 10]  = 24'h100000;
        for (int i = 0; i < 3; i++) s[i] = $urandom_range(50, FLEN - 50);

        t = 0; frame_idx = 0; mbank = 0; rst_cnt = 0; fs2 = -1; fs3 = -1;
        pend = 0; rst_done = 0; row_lat = 4'd0; hold = 6'd0;
        for (int i = 0; i < 5; i++) mc_cnt[i] = 0;

        for (int cyc = 0; cyc < 70000 && frame_idx < 4; cyc++) begin
            @(negedge clk);
            cur_cyc = cyc;
            decode(t, kind, row, pl, col, k);

            if (cyc >= 3 && frame_idx == 1 && !rst_done && kind == 2 && row == 7 && pl == 2) begin
                rst_cnt  = 3;
                rst_done = 1;
            end
            rst = (cyc < 3) || (rst_cnt > 0);
            if (rst_cnt > 0) rst_cnt--;

            if (rst) swap_req = 1'b0;
            else case (frame_idx)
                0: swap_req = (t == s[0]) || (t == s[1]) || (t == s[2]);
                1: swap_req = (t == 100) || ($urandom_range(0, 999) == 0);
                3: swap_req = (kind == 3);
                default: swap_req = 1'b0;
            endcase
            #1;

            if (rst) begin
                exp_v = {1'b0, 12'd0, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
            end else begin
                exp_mc  = (kind == 3) && (pend || swap_req);
                exp_col = (kind == 0 && k == 2) ? pix_bits(mbank, row, col, pl) : hold;
                exp_v = {(kind == 0 && k < 2),
                         (kind == 0 && k < 2) ? 12'((row + (k == 1 ? 16 : 0)) * COLS + col) : 12'd0,
                         exp_mc, exp_col, row_lat,
                         (kind == 0 && k == 3), (kind == 1), (kind != 2), (kind == 3)};
            end
            got_v = {mem_rd, mem_addr, mem_change, r1, g1, b1, r2, g2, b2,
                     row_addr, pclk, lat, oe_n, frame_start};
            chk("outputs", 32'(got_v), 32'(exp_v));

            if (mem_change) mc_cnt[frame_idx]++;
            if (frame_start && frame_idx == 2) fs2 = cyc;
            if (frame_start && frame_idx == 3) fs3 = cyc;

            if (rst) begin
                t = 0; pend = 0; row_lat = 4'd0; hold = 6'd0;
                if (frame_idx == 1) frame_idx = 2;
            end else begin
                if (kind == 1) row_lat = 4'(row);
                if (kind == 0 && k == 2) hold = exp_col;
                if (kind == 3) begin
                    if (exp_mc) mbank = 1 - mbank;
                    pend = 0;
                    frame_idx++;
                    t = 0;
                end else begin
                    if (swap_req) pend = 1;
                    t++;
                end
            end
        end

        rst = 1'b0;
        swap_req = 1'b0;
        chk("frames_done", 32'(frame_idx), 32'd4);
        chk("mc_3_pulses", 32'(mc_cnt[0]), 32'd1);
        chk("mc_after_rst", 32'(mc_cnt[2]), 32'd0);
        chk("mc_at_fe", 32'(mc_cnt[3]), 32'd1);
        chk("frame_period", 32'(fs3 - fs2), 32'd16929);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter COLS, default 64: panel columns.
REQ-002 SHALL have parameter BASE_TIME, default 32: display cycles for bit-plane 0.
REQ-003 SHALL have parameter PLANES, default 4: bit-planes per channel, taken from bits [7:8-PLANES] of each 8-bit channel.
REQ-004 Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- swap_req  in  1  writer requests buffer exchange at the next frame boundary.
- mem_rd  out  1  read strobe to double-buffered pixel memory.
- mem_addr  out  12  pixel address = row*COLS + col.
- mem_rdata  in  24  pixel data, {R[23:16],G[15:8],B[7:0]}.
- mem_change  out  1  one-cycle buffer-exchange pulse to pixel memory.
- r1,g1,b1,r2,g2,b2  out  1 each  HUB75 colour bits, upper and lower half.
- row_addr  out  4  HUB75 row select A..D.
- pclk, lat, oe_n  out  1 each  HUB75 shift clock, latch, active-low output enable.
- frame_start  out  1  one-cycle pulse at each frame boundary.

Function
REQ-005 Panel SHALL be 64x32 at 1/16 scan; scan row r (0..15) drives memory rows r (upper) and r+16 (lower).
REQ-006 Memory read latency SHALL be 1 cycle: mem_rdata is sampled on the rising edge after mem_rd/mem_addr are presented.
REQ-007 FSM states SHALL be SHIFT, LATCH, DISPLAY, FRAME_END.
REQ-008 SHIFT SHALL process each column c in 4 cycles:
- k0: mem_rd=1, addr=r*64+c.
- k1: capture upper pixel; mem_rd=1, addr=(r+16)*64+c.
- k2: capture lower pixel; drive r1..b2 = plane bit p of each channel; pclk=0.
- k3: pclk=1.
REQ-009 mem_rd SHALL be 0 outside k0/k1; pclk SHALL be 0 outside k3.
REQ-010 After column COLS-1 k3, the FSM SHALL enter LATCH: 1 cycle, lat=1, row_addr<=r, oe_n=1.
REQ-011 DISPLAY SHALL last BASE_TIME<<p cycles with oe_n=0; oe_n SHALL be 1 in all other states.
REQ-012 After DISPLAY, p SHALL increment. On p wrap from PLANES-1 to 0, r SHALL increment. On r wrap from 15 to 0, the FSM SHALL enter FRAME_END; otherwise it SHALL return to SHIFT at col 0.
REQ-013 FRAME_END SHALL last 1 cycle with frame_start=1; mem_change=1 iff swap pending; then pending clears and the FSM enters SHIFT at r=0, p=0, col=0.
REQ-014 swap_req high on any cycle SHALL set swap pending, including the FRAME_END cycle itself, which yields mem_change that same cycle.
REQ-015 Multiple swap_req before a boundary SHALL yield exactly one mem_change.
REQ-016 Frame length SHALL be 16*(PLANES*(4*COLS+1) + BASE_TIME*(2^PLANES-1)) + 1 cycles.
REQ-017 Column, plane and row counters SHALL wrap only as specified, with no skipped or repeated column.
REQ-018 r1..b2 SHALL hold their value from k2 through k3 of each column.

Reset
REQ-019 While rst=1: state SHIFT, r=p=col=0, k=0, swap pending cleared.
REQ-020 While rst=1, outputs SHALL be: mem_rd=0, mem_addr=0, mem_change=0, colour bits=0, row_addr=0, pclk=0, lat=0, oe_n=1, frame_start=0.
REQ-021 Reset asserted mid-frame SHALL take effect on the next edge: no mem_change or frame_start pulse, oe_n=1 immediately.
REQ-022 The first mem_rd SHALL occur on the first cycle after rst deasserts.

Verification
REQ-023 BASE_TIME=2, no swap_req: frame_start period is 16929 cycles; mem_change is never asserted.
REQ-024 Memory model, latency 1, with pixel(row,col)=0xF0F0F0 only at row 0 col 5 and row 16 col 5: in plane 3 of row 0, the 6th pclk rise has r1=g1=b1=r2=g2=b2=1; all other rises have colour bits 0.
REQ-025 Pixel 0x100000 at row 3: R bit 4 appears only in plane 0. DISPLAY for plane 0 = 2 cycles oe_n=0; plane 3 = 16 cycles.
REQ-026 swap_req pulsed 3 times mid-frame: exactly one mem_change, coincident with the next frame_start.
REQ-027 swap_req asserted exactly in the FRAME_END cycle: mem_change=1 in that cycle.
REQ-028 rst during DISPLAY of row 7: next cycle oe_n=1 and row_addr=0; mem_rd rises one cycle after rst falls with mem_addr=0.
